// File: rtl/chip8_key_ctrl.sv
// CHIP-8 4x4 hex keypad scanner, per-key debouncer, EX9E/EXA1 query and FX0A wait handshake.
// Build option: define CHIP8_KEY_RELEASE_EN to complete FX0A on release of the captured key.
module chip8_key_ctrl #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  column,
    input  logic [3:0]  row,
    output logic [15:0] keys,
    input  logic [3:0]  query_key,
    output logic        query_pressed,
    input  logic        wait_start,
    input  logic        wait_cancel,
    output logic        wait_busy,
    output logic        wait_done,
    output logic [3:0]  wait_key
);

    localparam int unsigned   CW         = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB_LAST    = 4'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_PRESS   = 2'd1
`ifdef CHIP8_KEY_RELEASE_EN
        ,
        S_WAIT_RELEASE = 2'd2
`endif
    } state_t;

    logic [CW-1:0] r_dwell;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_column;
    logic [15:0]   r_raw;
    logic [15:0]   r_keys;
    logic [3:0]    r_db_cnt [16];
    logic          r_query_pressed;
    state_t        r_state;
    logic [15:0]   r_held;
    logic          r_busy;
    logic          r_done;
    logic [3:0]    r_wait_key;

    logic          w_dwell_end;
    logic          w_frame_end;
    logic [15:0]   w_frame;
    logic [15:0]   w_held_live;
    logic [15:0]   w_eligible;
    logic          w_elig_any;
    logic [3:0]    w_elig_idx;

    assign w_dwell_end = (r_dwell == DWELL_LAST);
    assign w_frame_end = w_dwell_end && (r_col_idx == 2'd3);

    // ------------------------------------------------------------------
    // Column scan: rows are latched on the last dwell cycle of each column
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell   <= '0;
            r_col_idx <= '0;
            r_column  <= 4'b0001;
            r_raw     <= '0;
        end else if (w_dwell_end) begin
            r_dwell   <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            r_column  <= {r_column[2:0], r_column[3]};
            for (int unsigned r = 0; r < 4; r++) begin
                r_raw[{2'(r), r_col_idx}] <= row[r];
            end
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // Column 3 is folded in directly so the debouncer sees the whole matrix on this edge
    always_comb begin
        w_frame = r_raw;
        for (int unsigned r = 0; r < 4; r++) begin
            w_frame[{2'(r), 2'd3}] = row[r];
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounce, stepped once per full-matrix sample
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keys <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else if (w_frame_end) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (w_frame[4'(i)] != r_keys[4'(i)]) begin
                    if (r_db_cnt[i] >= DB_LAST) begin
                        r_keys[4'(i)] <= ~r_keys[4'(i)];
                        r_db_cnt[i]   <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 4'd1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_query_pressed <= 1'b0;
        end else begin
            r_query_pressed <= r_keys[query_key];
        end
    end

    // ------------------------------------------------------------------
    // FX0A wait: keys held at start stay masked until they are released
    // ------------------------------------------------------------------
    assign w_held_live = r_held & r_keys;
    assign w_eligible  = r_keys & ~w_held_live;

    always_comb begin
        w_elig_any = 1'b0;
        w_elig_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (w_eligible[4'(i)] && !w_elig_any) begin
                w_elig_any = 1'b1;
                w_elig_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_held     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wait_key <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wait_start && !wait_cancel) begin
                        r_held  <= r_keys;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_PRESS;
                    end
                end
                S_WAIT_PRESS: begin
                    if (wait_cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_held <= w_held_live;
                        if (w_elig_any) begin
                            r_wait_key <= w_elig_idx;
`ifdef CHIP8_KEY_RELEASE_EN
                            r_state    <= S_WAIT_RELEASE;
`else
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef CHIP8_KEY_RELEASE_EN
                S_WAIT_RELEASE: begin
                    if (wait_cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!r_keys[r_wait_key]) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign column        = r_column;
    assign keys          = r_keys;
    assign query_pressed = r_query_pressed;
    assign wait_busy     = r_busy;
    assign wait_done     = r_done;
    assign wait_key      = r_wait_key;

endmodule

// File: doc/chip8_key_ctrl.md
Name: chip8_key_ctrl

Overview:
Scan sequencer and CPU-facing controller for the 4x4 CHIP-8 hex keypad matrix. It drives the column strobes with a programmable dwell time and debounces each of the 16 keys. It serves the CPU's two keypad needs: single-key query for EX9E/EXA1, and the blocking wait-for-key handshake for FX0A. It sits between the matrix pins and the CPU execute stage.

Parameters:
SCAN_DIV, 1000, clk cycles per column dwell; rows are sampled on the last cycle of the dwell; legal range >= 2.
DEBOUNCE, 4, number of consecutive full-matrix samples that must disagree with the stable state before that state flips; legal range 1..15.

Ports:
clk  input  1  system clock; the block's single clock domain.
rst_n  input  1  asynchronous active-low reset.
column  output  4  one-hot active-high column strobe.
row  input  4  row sense lines, active-high, already synchronised.
keys  output  16  debounced key state; bit index = row*4 + column.
query_key  input  4  key index queried by the CPU.
query_pressed  output  1  registered keys[query_key].
wait_start  input  1  one-cycle pulse that begins an FX0A wait.
wait_cancel  input  1  aborts an active wait.
wait_busy  output  1  high while a wait is in progress.
wait_done  output  1  one-cycle pulse when a wait completes.
wait_key  output  4  captured key index; held stable until the next wait_start.

Behaviour:
- Reset values (async, rst_n low): column = 4'b0001, column index 0, dwell counter 0, keys = 0, all debounce counters 0, query_pressed 0, FSM IDLE, wait_busy 0, wait_done 0, wait_key 0.
- Scan:
  - Dwell counter runs 0..SCAN_DIV-1.
  - On the cycle the count reaches SCAN_DIV-1, row[3:0] is sampled for the current column.
  - On the next cycle the column index advances 0->1->2->3->0, visiting all four columns, and column updates to match.
  - Column is strictly one-hot at all times; there is no blank cycle.
  - One full-matrix sample period = 4*SCAN_DIV cycles.
- Debounce, per key:
  - The counter is 4 bits wide and saturates at DEBOUNCE.
  - On each sample where the raw value differs from keys[i], the counter increments.
  - On each sample where the raw value equals keys[i], the counter clears to 0.
  - When the counter reaches DEBOUNCE, keys[i] flips and the counter clears.
  - A single differing sample therefore never changes keys when DEBOUNCE > 1.
- Query: query_pressed <= keys[query_key] every cycle; 1-cycle latency from any change of query_key or keys.
- Wait FSM, states IDLE, WAIT_PRESS, WAIT_RELEASE:
  - IDLE: wait_start -> snapshot the current keys into held_mask, go to WAIT_PRESS, wait_busy=1. Keys held at start are ignored until they are released.
  - WAIT_PRESS:
    - Any held_mask bit whose key reads 0 is cleared.
    - A key is eligible when keys=1 and held_mask=0.
    - If one or more keys are eligible, capture the lowest eligible index into wait_key.
    - With CHIP8_KEY_RELEASE_EN defined, go to WAIT_RELEASE; otherwise complete immediately.
  - WAIT_RELEASE: when keys[wait_key] returns to 0, complete. Other keys are ignored in this state.
  - Complete: wait_done pulses for 1 cycle, wait_busy drops in the same cycle, FSM returns to IDLE.
  - wait_cancel in WAIT_PRESS or WAIT_RELEASE -> IDLE, wait_busy=0, no wait_done, wait_key unchanged.
  - wait_cancel has priority over a completion in the same cycle.
  - wait_start while busy is ignored.
  - wait_start and wait_cancel together in IDLE: cancel wins and the FSM stays IDLE.
- Reset mid-scan or mid-wait: immediate return to the reset values above; no wait_done is produced.

Optional Feature:
CHIP8_KEY_RELEASE_EN:
- Defined: FX0A completes on release of the captured key, matching the original COSMAC VIP. The WAIT_RELEASE state exists.
- Undefined: FX0A completes in the cycle after the eligible press is registered. The WAIT_RELEASE state and its logic are absent.
- All other behaviour is identical.

Test Plan:
- Reset then free-run with SCAN_DIV=4 -> column sequence 0001,0010,0100,1000 repeating, each held exactly 4 cycles; keys=0.
- Hold row[2]=1 only while column=4'b0010, DEBOUNCE=4 -> keys[9] rises after the 4th matrix sample (about 16*SCAN_DIV cycles); query_key=9 -> query_pressed=1 one cycle later.
- Single-sample glitch on key 5 with DEBOUNCE=4 -> keys stays 0; counter clears on the next agreeing sample.
- Key 3 held before wait_start, then key 12 pressed -> wait_key=12; key 3 is not captured while continuously held. Release-enabled build: wait_done only after key 12 is released.
- Keys 4 and 11 become stable in the same sample during WAIT_PRESS -> wait_key=4.
- wait_cancel during WAIT_PRESS -> wait_busy=0 next cycle, no wait_done. rst_n low mid-wait -> all outputs at reset values asynchronously.
